// File: rtl/ex_shift_seq.sv
// EX-stage sequential logarithmic shifter: one shamt bit per cycle, stalls the pipe while busy.
// Optional macro EX_SHIFT_EARLY_EXIT_EN: finish as soon as no shamt bits remain.
module ex_shift_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  input  logic            flush,
  output logic            ready,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  amt_q, amt_d;
  logic [SHW-1:0]  idx_q, idx_d;
  logic            left_q, left_d;
  logic            sign_q, sign_d;
  logic            done_q, done_d;

  logic [SHW-1:0]  dist_s;
  logic [XLEN-1:0] step_s;
  logic            last_s;
  logic            accept_s;

  // One logarithmic stage: shift by 2**idx when the current shamt bit is set
  always_comb begin
    dist_s = SHW'(1) << idx_q;
    step_s = data_q;
    if (!amt_q[0]) begin
      step_s = data_q;
    end else if (left_q) begin
      step_s = data_q << dist_s;
    end else begin
      step_s = (data_q >> dist_s) | (sign_q ? ~({XLEN{1'b1}} >> dist_s) : {XLEN{1'b0}});
    end
`ifdef EX_SHIFT_EARLY_EXIT_EN
    last_s = (amt_q[SHW-1:1] == '0) || (idx_q == SHW'(SHW - 1));
`else
    last_s = (idx_q == SHW'(SHW - 1));
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    result_d = result_q;
    amt_d    = amt_q;
    idx_d    = idx_q;
    left_d   = left_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    accept_s = start && !flush && (state_q != RUN);
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          data_d = a;
          amt_d  = shamt;
          idx_d  = '0;
          left_d = (op == 2'b00);
          sign_d = (op == 2'b10) && a[XLEN-1];
          if (shamt == '0) begin
            result_d = a;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          data_d = step_s;
          amt_d  = amt_q >> 1;
          idx_d  = idx_q + SHW'(1);
          if (last_s) begin
            result_d = step_s;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      result_q <= '0;
      amt_q    <= '0;
      idx_q    <= '0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      amt_q    <= amt_d;
      idx_q    <= idx_d;
      left_q   <= left_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign stall  = (start && ready && !flush) || (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_shift_seq.sv
// Self-checking bench for ex_shift_seq: vector table plus corner sequences, scoreboard queue.
module tb_ex_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [4:0]  shamt = 5'd0;
  logic        flush = 1'b0;
  logic        ready, stall, done;
  logic [31:0] result;

  ex_shift_seq #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .shamt(shamt),
    .flush(flush), .ready(ready), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl[12];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] pend_exp = 32'h0;
  logic [4:0]  pend_sh = 5'd0;
  logic [31:0] last_exp = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Edges from the accept edge until done is visible
  function automatic int lat(input logic [4:0] s);
    int r;
    r = 0;
    if (s != 5'd0) begin
`ifdef EX_SHIFT_EARLY_EXIT_EN
      for (int i = 0; i < 5; i++) if (s[i]) r = i + 1;
`else
      r = 5;
`endif
    end
    return r;
  endfunction

  task automatic monitor();
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.due);
        last_exp = e.res;
      end
    end else if (q.size() > 0 && cyc >= q[0].due) begin
      chk("done_missing", 32'd0, 32'd1);
      void'(q.pop_front());
    end
  endtask

  // One clock: check handshake outputs, update the model, advance, sample at negedge
  task automatic tick();
    logic exp_ready, exp_stall, acc;
    #1;
    exp_ready = (q.size() == 0);
    exp_stall = (start && exp_ready && !flush) || !exp_ready;
    chk("ready", {31'd0, ready}, {31'd0, exp_ready});
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    acc = start && exp_ready && !flush && rst_n;
    if (flush && !exp_ready) q.delete();
    if (acc) q.push_back('{res: pend_exp, due: cyc + 1 + lat(pend_sh)});
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] s, input logic [31:0] expv);
    op = o; a = av; shamt = s; start = 1'b1;
    pend_exp = expv; pend_sh = s;
    tick();
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    shamt = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && q.size() > 0; n++) tick();
    if (q.size() > 0) begin
      chk("timeout", 32'd0, 32'd1);
      q.delete();
    end
  endtask

  initial begin
    tbl[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    tbl[1]  = '{2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F};
    tbl[2]  = '{2'b01, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
    tbl[3]  = '{2'b01, 32'h8000_00F0, 5'd4,  32'h0800_000F};
    tbl[4]  = '{2'b00, 32'h0000_0003, 5'd1,  32'h0000_0006};
    tbl[5]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    tbl[6]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    tbl[7]  = '{2'b11, 32'hF000_0000, 5'd8,  32'h00F0_0000};
    tbl[8]  = '{2'b00, 32'h1234_5678, 5'd16, 32'h5678_0000};
    tbl[9]  = '{2'b10, 32'h8765_4321, 5'd0,  32'h8765_4321};
    tbl[10] = '{2'b00, 32'hDEAD_BEEF, 5'd5,  32'hD5B7_DDE0};
    tbl[11] = '{2'b10, 32'hF000_0000, 5'd3,  32'hFE00_0000};

    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i].op, tbl[i].a, tbl[i].sh, tbl[i].exp);
      wait_idle();
      tick();
      chk("result_held", result, tbl[i].exp);
    end

    // Back-to-back: new request in the DONE cycle
    start_op(2'b00, 32'h0000_00FF, 5'd20, 32'h0FF0_0000);
    wait_idle();
    start_op(2'b00, 32'h0000_0003, 5'd1, 32'h0000_0006);
    wait_idle();
    tick();

    // Flush in the second RUN cycle: no done, result untouched
    start_op(2'b01, 32'h0000_00F0, 5'd7, 32'h0000_0001);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_result", result, 32'h0000_0006);
    for (int n = 0; n < 8; n++) tick();

    // Flush beats start while idle
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'h1; shamt = 5'd0;
    tick();
    start = 1'b0; flush = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    chk("flush_start_result", result, 32'h0000_0006);

    // Asynchronous reset mid-RUN
    start_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready}, 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("post_rst_result", result, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
